instr_loader: RTL and testbench

Byte-stream program loader sitting directly upstream of `riscv_single_top`'s instruction memory. It accepts a framed little-endian byte stream (length header, instruction words, optional checksum), writes each assembled 32-bit word into instruction memory at consecutive word addresses, and holds the core in reset until the image is complete. It lets benches and the board load programs without hierarchical writes into `instr_mem`.

---
 rtl/instr_loader_pkg.sv | 20 ++
 rtl/instr_loader_byte_packer.sv | 40 ++++
 rtl/instr_loader.sv | 178 +++++++++++++++++
 tb/tb_instr_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader_pkg
// Brief    : Shared state encoding and framing constants for instr_loader.
// Revision : 1.0 - initial release
// ============================================================================
package instr_loader_pkg;

    localparam int LOADER_HDR_BYTES = 4;

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_DATA = 3'd1,
        S_CSUM = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/instr_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_packer
// Brief    : Assembles four little-endian bytes into a 32-bit word; the
//            word_valid pulse coincides with the accepted 4th byte.
// Revision : 1.0 - initial release
// ============================================================================
module byte_packer
    import instr_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_byte_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    localparam logic [1:0] c_last = 2'(LOADER_HDR_BYTES - 1);

    logic [1:0]  r_cnt;
    logic [23:0] r_shift;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt   <= 2'd0;
            r_shift <= 24'd0;
        end else if (i_byte_en) begin
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= {i_byte, r_shift[23:8]};
        end
    end

    // The 4th byte bypasses the register so the word is usable on its own edge.
    assign o_word       = {i_byte, r_shift};
    assign o_word_valid = i_byte_en && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader
// Brief    : Framed byte-stream loader for the instruction memory; holds the
//            core in reset until the image is in. Optional trailing XOR
//            checksum enabled by defining INSTR_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        load_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        core_rst,
    output logic        done,
    output logic        err
);

    localparam logic [31:0] c_max_words = 32'd1 << ADDR_W;

    loader_state_e r_state;
    loader_state_e w_state_nxt;

    logic [ADDR_W:0] r_len;
    logic [ADDR_W:0] r_idx;
    logic [ADDR_W:0] w_idx_inc;
    logic            w_xfer;
    logic            w_pack_en;
    logic            w_clear;
    logic [31:0]     w_word;
    logic            w_word_valid;
    logic            w_data_wr;

    logic            r_in_ready;
    logic            r_mem_we;
    logic [31:0]     r_mem_addr;
    logic [31:0]     r_mem_wd;
    logic            r_core_rst;
    logic            r_done;
    logic            r_err;

    assign w_xfer    = in_valid && r_in_ready;
    assign w_pack_en = w_xfer && ((r_state == S_HDR) || (r_state == S_DATA));
    assign w_clear   = (r_state == S_DONE) && load_req;
    assign w_data_wr = (r_state == S_DATA) && w_word_valid;
    assign w_idx_inc = r_idx + (ADDR_W + 1)'(1);

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_clear),
        .i_byte_en    (w_pack_en),
        .i_byte       (in_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam loader_state_e c_after_data = S_CSUM;

    logic [7:0] r_csum;

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_csum <= 8'd0;
        end else if (w_xfer && (r_state == S_DATA)) begin
            r_csum <= r_csum ^ in_data;
        end
    end
`else
    localparam loader_state_e c_after_data = S_DONE;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HDR: begin
                if (w_word_valid) begin
                    if (w_word == 32'd0) begin
                        w_state_nxt = c_after_data;
                    end else if (w_word > c_max_words) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_word_valid && (w_idx_inc == r_len)) begin
                    w_state_nxt = c_after_data;
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (w_xfer) begin
                    w_state_nxt = (in_data == r_csum) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE: begin
                if (load_req) begin
                    w_state_nxt = S_HDR;
                end
            end
            S_ERR: begin
                w_state_nxt = S_ERR;
            end
            default: begin
                w_state_nxt = S_ERR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len <= '0;
            r_idx <= '0;
        end else if (w_clear) begin
            r_idx <= '0;
        end else if ((r_state == S_HDR) && w_word_valid) begin
            r_len <= w_word[ADDR_W:0];
            r_idx <= '0;
        end else if (w_data_wr) begin
            r_idx <= w_idx_inc;
        end
    end

    // Outputs follow the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= 32'd0;
            r_mem_wd   <= 32'd0;
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_in_ready <= (w_state_nxt == S_HDR) || (w_state_nxt == S_DATA) ||
                          (w_state_nxt == S_CSUM);
            r_mem_we   <= w_data_wr;
            if (w_data_wr) begin
                r_mem_addr <= 32'({r_idx[ADDR_W-1:0], 2'b00});
                r_mem_wd   <= w_word;
            end
            r_core_rst <= (w_state_nxt != S_DONE);
            r_done     <= (w_state_nxt == S_DONE);
            r_err      <= (w_state_nxt == S_ERR);
        end
    end

    assign in_ready = r_in_ready;
    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_wd   = r_mem_wd;
    assign core_rst = r_core_rst;
    assign done     = r_done;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_loader
// Brief    : Randomized self-checking bench for instr_loader against a
//            word-list reference of the expected memory image.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

    localparam int ADDR_W = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        load_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        core_rst;
    logic        done;
    logic        err;

    int n_compared   = 0;
    int n_mismatched = 0;
    int ready_stalls = 0;

    logic [31:0] img[$];
    logic [31:0] got_addr[$];
    logic [31:0] got_wd[$];

    always #5 clk = ~clk;

    instr_loader #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .load_req (load_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .core_rst (core_rst),
        .done     (done),
        .err      (err)
    );

    always @(negedge clk) begin
        if (mem_we) begin
            got_addr.push_back(mem_addr);
            got_wd.push_back(mem_wd);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit count_stall);
        int waited = 0;
        repeat (gap) @(negedge clk);
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check_eq("ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        if (count_stall) ready_stalls += waited;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap, input bit first);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], $urandom_range(0, max_gap), !(first && k == 0));
        end
    endtask

    // Full frame for img: length header, LE words, then XOR byte when enabled.
    task automatic send_image(input int max_gap, input logic [7:0] flip);
        logic [7:0] csum = 8'd0;
        send_word(32'(img.size()), max_gap, 1'b1);
        foreach (img[i]) begin
            send_word(img[i], max_gap, 1'b0);
            csum = csum ^ img[i][7:0] ^ img[i][15:8] ^ img[i][23:16] ^ img[i][31:24];
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(csum ^ flip, $urandom_range(0, max_gap), 1'b1);
`else
        if (flip != 8'd0) csum = csum ^ flip;
`endif
    endtask

    task automatic expect_done(input string tag);
        check_eq({tag, "_done"},     32'(done),     32'd1);
        check_eq({tag, "_core_rst"}, 32'(core_rst), 32'd0);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check_eq({tag, "_err"},      32'(err),      32'd0);
    endtask

    task automatic expect_err(input string tag);
        check_eq({tag, "_err"},      32'(err),      32'd1);
        check_eq({tag, "_core_rst"}, 32'(core_rst), 32'd1);
        check_eq({tag, "_done"},     32'(done),     32'd0);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic verify_writes(input string tag);
        #1;
        check_eq({tag, "_nwrites"}, 32'(got_addr.size()), 32'(img.size()));
        for (int i = 0; i < img.size() && i < got_addr.size(); i++) begin
            check_eq({tag, "_addr"}, got_addr[i], 32'(4 * i));
            check_eq({tag, "_data"}, got_wd[i], img[i]);
        end
        got_addr.delete();
        got_wd.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        load_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        got_addr.delete();
        got_wd.delete();
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        check_eq("reload_core_rst", 32'(core_rst), 32'd1);
        check_eq("reload_done",     32'(done),     32'd0);
        check_eq("reload_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic random_image(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom);
    endtask

    initial begin
        logic [31:0] hdr;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        load_req = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_mem_we",   32'(mem_we),   32'd0);
        check_eq("rst_mem_addr", mem_addr,      32'd0);
        check_eq("rst_mem_wd",   mem_wd,        32'd0);
        check_eq("rst_core_rst", 32'(core_rst), 32'd1);
        check_eq("rst_done",     32'(done),     32'd0);
        check_eq("rst_err",      32'(err),      32'd0);
        rst = 1'b0;

        // Directed image, back-to-back bytes.
        img = '{32'h0042_1013, 32'h0042_9213, 32'h0042_1213};
        ready_stalls = 0;
        send_image(0, 8'd0);
        expect_done("b2b");
        verify_writes("b2b");
        check_eq("b2b_stalls", 32'(ready_stalls), 32'd0);

`ifdef INSTR_LOADER_CHECKSUM_EN
        // Corrupted checksum: sticky error that ignores load_req.
        do_reset();
        send_image(0, 8'h01);
        expect_err("bad_csum");
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("bad_csum_sticky", 32'(err), 32'd1);
        check_eq("bad_csum_hold",   32'(core_rst), 32'd1);
        got_addr.delete();
        got_wd.delete();
`endif

        // Length overflow: N = 2^ADDR_W + 1.
        do_reset();
        hdr = (32'd1 << ADDR_W) + 32'd1;
        for (int k = 0; k < 4; k++) send_byte(hdr[8*k +: 8], 0, 1'b0);
        expect_err("ovf");
        repeat (3) @(negedge clk);
        #1;
        check_eq("ovf_no_write", 32'(got_addr.size()), 32'd0);

        // Random gaps on a 2-word image.
        do_reset();
        random_image(2);
        ready_stalls = 0;
        send_image(5, 8'd0);
        expect_done("gaps");
        verify_writes("gaps");
        check_eq("gaps_stalls", 32'(ready_stalls), 32'd0);

        // Abort after 6 data bytes, then a fresh 1-word image.
        do_reset();
        random_image(2);
        send_word(32'd2, 0, 1'b1);
        send_word(img[0], 0, 1'b0);
        send_byte(img[1][7:0], 0, 1'b0);
        send_byte(img[1][15:8], 0, 1'b0);
        #1;
        check_eq("abort_pre_writes", 32'(got_addr.size()), 32'd1);
        do_reset();
        check_eq("abort_core_rst", 32'(core_rst), 32'd1);
        random_image(1);
        send_image(0, 8'd0);
        expect_done("abort");
        verify_writes("abort");

        // Reload via load_req.
        pulse_load_req();
        img = '{32'hDEAD_BEEF};
        send_image(1, 8'd0);
        expect_done("reload");
        verify_writes("reload");

        // Random images, including empty ones, chained by load_req.
        for (int t = 0; t < 6; t++) begin
            pulse_load_req();
            random_image((t == 0) ? 0 : $urandom_range(0, 6));
            send_image($urandom_range(0, 2), 8'd0);
            expect_done("rnd");
            verify_writes("rnd");
        end

        // Largest legal image: exactly 2^ADDR_W words.
        pulse_load_req();
        random_image(1 << ADDR_W);
        send_image(0, 8'd0);
        expect_done("max");
        verify_writes("max");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
